mxu_result_drain: RTL and testbench
===================================

// Module: mxu_result_drain
// PURPOSE
// - Downstream stage of the temporal MXU. Captures the full DIM x DIM result matrix when the
//   MXU asserts out_valid, holds it in a 2-entry ping-pong buffer, and streams it out one row
//   per beat over a valid/ready interface.
// - Decouples MXU completion from a back-pressuring consumer (writeback/SRAM port).
// PARAMETERS
// - DIM           16               matrix dimension (rows = cols)
// - BIT_WIDTH     2                MXU operand width
// - OUT_BIT_WIDTH 2*BIT_WIDTH      result element width (matches MXU out)
// - ROW_W         $clog2(DIM)>0?$clog2(DIM):1   row index width
// - DROP_W        8                drop-counter width
// PORTS
// - clk       in   1                           clock
// - reset_n   in   1                           synchronous active-low reset
// - in_valid  in   1                           MXU out_valid (level, may stay high >1 cycle)
// - in_data   in   [DIM][DIM][OUT_BIT_WIDTH]   MXU out matrix
// - in_space  out  1                           1 when at least one buffer entry is free
// - m_valid   out  1                           row beat valid
// - m_ready   in   1                           consumer accepts beat
// - m_data    out  [DIM][OUT_BIT_WIDTH]        current row, element [c] = in_data[row][c]
// - m_row     out  ROW_W                       row index of current beat
// - m_last    out  1                           m_valid && m_row == DIM-1
// - drop_cnt  out  DROP_W                      saturating count of dropped matrices
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-low (reset_n).
// - Reset (reset_n=0 at posedge): buffers, wr_ptr, rd_ptr, occ=0, row=0, in_valid_q=0,
//   drop_cnt=0. Outputs: m_valid=0, m_data=0, m_row=0, m_last=0, in_space=1. Mid-stream reset
//   discards all buffered data. No partial beat survives.
// - Capture event: cap = in_valid & ~in_valid_q (rising edge only). A level held for N cycles
//   is one matrix. in_valid_q is registered every cycle.
// - beat = m_valid & m_ready; done = beat & m_last.
// - Occupancy occ in 0..2. m_valid = (occ != 0). in_space = (occ != 2).
// - cap with (occ<2 | done): write in_data into buf[wr_ptr], toggle wr_ptr.
// - cap with (occ==2 & ~done): drop matrix, drop_cnt += 1, saturating at 2^DROP_W-1.
//   Buffers are unchanged.
// - Simultaneous cap & done at occ==2: accepted. The freed entry is reused the same edge.
// - occ_next = occ + accepted_cap - done.
// - Stream FSM per entry, states IDLE (occ==0) and STREAM (occ>0):
//   - beat with row<DIM-1: row += 1.
//   - done: row <= 0, toggle rd_ptr. Stay in STREAM if occ_next>0, else go to IDLE.
// - m_data/m_row are combinational from buf[rd_ptr][row] and row. Zero when occ==0.
//   Stable while m_valid & ~m_ready (AXI-style hold). m_valid never drops without a beat.
// - Latency: a cap into an empty buffer gives m_valid=1 on the next cycle with m_row=0.
//   A full matrix drains in DIM accepted beats, min DIM cycles.
// - Back-to-back matrices: the first beat of entry 2 is presented the cycle after the m_last
//   beat of entry 1. No bubble.
// - Elements pass through unmodified (two's complement, OUT_BIT_WIDTH bits, no resizing).
// - DIM==1: every beat is m_last.
// CONFIGURATION
// - MXU_DRAIN_PARITY_EN defined: adds port m_parity (out, 1) = ^m_data (even parity over
//   the full row), valid with m_valid, 0 at reset/empty.
// - MXU_DRAIN_PARITY_EN undefined: no m_parity port, no parity logic. All other behaviour
//   is identical.
// TESTING
// - Reset, then in_valid held 3 cycles, DIM=4, in_data[r][c]=r*4+c, m_ready=1 -> one matrix.
//   Beats rows 0..3 on 4 consecutive cycles, m_data row r = {r*4+3..r*4}, m_last on row 3.
//   drop_cnt=0.
// - m_ready=0 for 5 cycles after capture -> m_valid=1, m_row=0, m_data stable all 5 cycles.
//   Rows 0..3 then follow with m_ready=1.
// - Three caps 2 cycles apart with m_ready=0 -> first two buffered, in_space=0,
//   third dropped, drop_cnt=1. Drain yields matrix1 then matrix2 contiguously.
// - occ=2, cap on the same cycle as the m_last beat -> capture accepted, drop_cnt unchanged.
//   Then 8 more beats stream matrix2 and then matrix3.
// - reset_n=0 at row 2 of a stream -> next cycle m_valid=0, m_row=0, in_space=1,
//   drop_cnt=0. A new cap streams from row 0.
// - MXU_DRAIN_PARITY_EN, row with elements 4'h1,4'h0,4'h0,4'h0 -> m_parity=1.
//   All-zero row -> m_parity=0.

Source files
------------

// File: rtl/mxu_result_drain.sv
// Result drain for the temporal MXU: latches each result matrix into a 2-entry ping-pong
// buffer and streams it one row per valid/ready beat. Optional row parity: MXU_DRAIN_PARITY_EN.
module mxu_result_drain #(
  parameter int DIM           = 16,
  parameter int BIT_WIDTH     = 2,
  parameter int OUT_BIT_WIDTH = 2*BIT_WIDTH,
  parameter int ROW_W         = ($clog2(DIM) > 0) ? $clog2(DIM) : 1,
  parameter int DROP_W        = 8
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         in_valid,
  input  logic [DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0]   in_data,
  output logic                                         in_space,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [DIM-1:0][OUT_BIT_WIDTH-1:0]            m_data,
  output logic [ROW_W-1:0]                             m_row,
  output logic                                         m_last,
  output logic [DROP_W-1:0]                            drop_cnt
`ifdef MXU_DRAIN_PARITY_EN
  ,
  output logic                                         m_parity
`endif
);

  typedef logic [DIM-1:0][DIM-1:0][OUT_BIT_WIDTH-1:0] mat_t;
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM-1);

  mat_t              r_buf [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;
  logic [ROW_W-1:0]  r_row;
  logic              r_in_valid_q;
  logic [DROP_W-1:0] r_drop_cnt;
  state_t            r_state;
  state_t            w_state_next;

  logic              w_cap;
  logic              w_beat;
  logic              w_done;
  logic              w_accept;
  logic              w_drop;
  logic [1:0]        w_occ_next;

  // A held in_valid level is a single matrix: only its rising edge captures.
  assign w_cap      = in_valid & ~r_in_valid_q;
  assign w_beat     = (r_state == S_STREAM) & m_ready;
  assign w_done     = w_beat & (r_row == LAST_ROW);
  assign w_accept   = w_cap & ((r_occ != 2'd2) | w_done);
  assign w_drop     = w_cap & ~w_accept;
  assign w_occ_next = r_occ + {1'b0, w_accept} - {1'b0, w_done};

  assign m_valid  = (r_occ != 2'd0);
  assign in_space = (r_occ != 2'd2);
  assign m_last   = m_valid & (r_row == LAST_ROW);
  assign m_row    = m_valid ? r_row : '0;
  assign m_data   = m_valid ? r_buf[r_rd_ptr][r_row] : '0;
  assign drop_cnt = r_drop_cnt;

`ifdef MXU_DRAIN_PARITY_EN
  assign m_parity = ^m_data;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_occ_next != 2'd0) w_state_next = S_STREAM;
      S_STREAM: if (w_done && (w_occ_next == 2'd0)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_occ        <= 2'd0;
      r_row        <= '0;
      r_in_valid_q <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_in_valid_q <= in_valid;
      r_occ        <= w_occ_next;
      // When full, the entry freed by the m_last beat is the one wr_ptr points at.
      if (w_accept) begin
        r_buf[r_wr_ptr] <= in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_done) begin
        r_row    <= '0;
        r_rd_ptr <= ~r_rd_ptr;
      end else if (w_beat) begin
        r_row <= r_row + ROW_W'(1);
      end
      if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mxu_result_drain.sv
// Bench for mxu_result_drain (DIM=4): queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mxu_result_drain;

  localparam int DIM    = 4;
  localparam int OBW    = 4;
  localparam int ROW_W  = 2;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef logic [DIM-1:0][DIM-1:0][OBW-1:0] mat_t;
  typedef logic [DIM-1:0][OBW-1:0]          row_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  mat_t              in_data;
  logic              in_space;
  logic              m_valid;
  logic              m_ready;
  row_t              m_data;
  logic [ROW_W-1:0]  m_row;
  logic              m_last;
  logic [DROP_W-1:0] drop_cnt;
`ifdef MXU_DRAIN_PARITY_EN
  logic              m_parity;
`endif

  int checks = 0;
  int errors = 0;

  mxu_result_drain #(.DIM(DIM), .BIT_WIDTH(2), .OUT_BIT_WIDTH(OBW), .ROW_W(ROW_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_space(in_space), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_row(m_row), .m_last(m_last), .drop_cnt(drop_cnt)
`ifdef MXU_DRAIN_PARITY_EN
    , .m_parity(m_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of whole matrices plus the row being offered.
  mat_t q[$];
  int   mrow    = 0;
  bit   prev_v  = 0;
  int   drops   = 0;
  bit   started = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      mrow    = 0;
      prev_v  = 0;
      drops   = 0;
      started = 1;
    end else begin
      if (q.size() != 0 && m_ready) begin
        if (mrow == DIM-1) begin
          void'(q.pop_front());
          mrow = 0;
        end else begin
          mrow++;
        end
      end
      if (in_valid && !prev_v) begin
        if (q.size() < 2) q.push_back(in_data);
        else if (drops < DROP_MAX) drops++;
      end
      prev_v = in_valid;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      bit   ev;
      row_t ed;
      int   er;
      ev = (q.size() != 0);
      er = ev ? mrow : 0;
      ed = ev ? q[0][mrow] : '0;
      chk("m_valid",  64'(m_valid),  64'(ev));
      chk("m_row",    64'(m_row),    64'(er));
      chk("m_data",   64'(m_data),   64'(ed));
      chk("m_last",   64'(m_last),   64'(ev && (er == DIM-1)));
      chk("in_space", 64'(in_space), 64'(q.size() != 2));
      chk("drop_cnt", 64'(drop_cnt), 64'(drops));
`ifdef MXU_DRAIN_PARITY_EN
      chk("m_parity", 64'(m_parity), 64'(^ed));
`endif
    end
  end

  mat_t mat_a;
  logic [15:0] row_lit [4];

  initial begin
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        mat_a[r][c] = OBW'(r*4 + c);
    row_lit[0] = 16'h3210; row_lit[1] = 16'h7654;
    row_lit[2] = 16'hBA98; row_lit[3] = 16'hFEDC;

    reset_n = 1'b0; in_valid = 1'b0; m_ready = 1'b0; in_data = mat_a;
    step(); step();
    @(negedge clk);
    chk("rst_m_valid",  64'(m_valid),  64'd0);
    chk("rst_in_space", 64'(in_space), 64'd1);
    chk("rst_drop",     64'(drop_cnt), 64'd0);
    chk("rst_m_row",    64'(m_row),    64'd0);
    reset_n = 1'b1;

    // One matrix, level held 3 cycles, consumer always ready.
    in_valid = 1'b1; m_ready = 1'b1;
    for (int r = 0; r < DIM; r++) begin
      step();
      if (r == 2) in_valid = 1'b0;
      @(negedge clk);
      chk("lit_row",  64'(m_row),  64'(r));
      chk("lit_data", 64'(m_data), 64'(row_lit[r]));
      chk("lit_last", 64'(m_last), 64'(r == 3));
    end
    step();
    @(negedge clk);
    chk("lit_empty", 64'(m_valid), 64'd0);
    chk("lit_drop0", 64'(drop_cnt), 64'd0);

    // Back-pressure: row 0 held steady for 5 stalled cycles.
    in_valid = 1'b1; m_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(m_valid), 64'd1);
      chk("stall_row",   64'(m_row),   64'd0);
      chk("stall_data",  64'(m_data),  64'h3210);
      step();
    end
    m_ready = 1'b1;
    repeat (6) step();

    // Three captures while stalled: third one dropped.
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = {$urandom, $urandom};
      in_valid = 1'b1; step();
      in_valid = 1'b0; step();
    end
    @(negedge clk);
    chk("full_drop",  64'(drop_cnt), 64'd1);
    chk("full_space", 64'(in_space), 64'd0);
    m_ready = 1'b1;
    repeat (10) step();

    // Capture coincident with the m_last beat while full.
    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_data = {$urandom, $urandom};
      in_valid = 1'b1; step();
      in_valid = 1'b0; step();
    end
    m_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("sim_last", 64'(m_last), 64'd1);
    in_data = {$urandom, $urandom};
    in_valid = 1'b1; step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sim_drop",  64'(drop_cnt), 64'd1);
    chk("sim_space", 64'(in_space), 64'd0);
    repeat (9) step();

    // Drop counter saturation.
    m_ready = 1'b0;
    for (int k = 0; k < 302; k++) begin
      in_data = {$urandom, $urandom};
      in_valid = 1'b1; step();
      in_valid = 1'b0; step();
    end
    @(negedge clk);
    chk("sat_drop", 64'(drop_cnt), 64'(DROP_MAX));

    // Reset in the middle of a stream.
    m_ready = 1'b1;
    step(); step();
    @(negedge clk);
    chk("pre_rst_row", 64'(m_row), 64'd2);
    reset_n = 1'b0; step();
    @(negedge clk);
    chk("mid_rst_valid", 64'(m_valid),  64'd0);
    chk("mid_rst_row",   64'(m_row),    64'd0);
    chk("mid_rst_space", 64'(in_space), 64'd1);
    chk("mid_rst_drop",  64'(drop_cnt), 64'd0);
    reset_n = 1'b1; in_data = mat_a; m_ready = 1'b0;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_row",  64'(m_row),  64'd0);
    chk("post_rst_data", 64'(m_data), 64'h3210);
    m_ready = 1'b1;
    repeat (5) step();

`ifdef MXU_DRAIN_PARITY_EN
    in_data = '0;
    in_data[0][0] = 4'h1;
    m_ready = 1'b1; in_valid = 1'b1; step(); in_valid = 1'b0;
    @(negedge clk);
    chk("par_one", 64'(m_parity), 64'd1);
    step();
    @(negedge clk);
    chk("par_zero", 64'(m_parity), 64'd0);
    repeat (4) step();
`endif

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      reset_n  = ($urandom_range(0, 299) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      m_ready  = (k % 1000 < 500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0; m_ready = 1'b1;
    repeat (10) step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
